altram_bus_ctrl: RTL and testbench

ALTRAM_BUS_CTRL -- requirements
Module: altram_bus_ctrl

---
 rtl/altram_bus_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_altram_bus_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/altram_bus_ctrl.sv
// rtl/altram_bus_ctrl.sv - 68000 alt-RAM window / shadow-ROM bus controller with DTACK and BERR generation
module altram_bus_ctrl #(
    parameter int                 N_WIN      = 2,
    parameter logic [4*N_WIN-1:0] WIN_LO     = {4'h8, 4'h4},
    parameter logic [4*N_WIN-1:0] WIN_HI     = {4'hB, 4'h7},
    parameter int                 WAIT_W     = 4,
    parameter int                 ALT_WAIT   = 2,
    parameter int                 BERR_CYC   = 255,
    parameter logic [3:0]         SHADOW_NIB = 4'hB
) (
    input  logic             clkosc,
    input  logic             rst,
    input  logic             as_n,
    input  logic             uds_n,
    input  logic             lds_n,
    input  logic             rw,
    input  logic [23:1]      a,
    input  logic             ext_dtack_n,
    input  logic             ram_rdy,
    input  logic             fast_en,
    output logic             dtack_n,
    output logic             berr_n,
    output logic [N_WIN-1:0] alt_sel,
    output logic             rom_sel,
    output logic [3:0]       a_remap,
    output logic             slow,
    output logic [N_WIN-1:0] win_en,
    output logic             shadow_on
);

    localparam logic [WAIT_W-1:0] ALT_WAIT_L = WAIT_W'(ALT_WAIT);
    localparam logic [7:0]        BERR_L     = 8'(BERR_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_WAIT, S_ACK, S_PASS, S_ERR, S_RELEASE
    } state_t;

    state_t state, state_d;

    logic [1:0] as_sync, uds_sync, lds_sync, ext_sync;
    logic       as_act, ext_act;

    logic [WAIT_W-1:0] wcnt, wcnt_d, wcnt_dec;
    logic [7:0]        pcnt, pcnt_d;
    logic              dtack_d, berr_d, rom_sel_d, shadow_d;
    logic              claimed_q, claimed_d, fast_en_q;
    logic [N_WIN-1:0]  alt_sel_d, win_en_d, win_onehot;
    logic [3:0]        a_remap_d;
    logic              is_cfg, is_shadow, win_hit;

    // Data strobes and RW are synchronised/accepted but do not steer the decode.
    logic unused_strobes;
    assign unused_strobes = &{1'b0, uds_sync, lds_sync, rw};

    assign as_act  = ~as_sync[1];
    assign ext_act = ~ext_sync[1];

    // Two-flop synchronisers for the asynchronous 68000 strobes and motherboard DTACK.
    always_ff @(posedge clkosc) begin
        if (rst) begin
            as_sync  <= 2'b11;
            uds_sync <= 2'b11;
            lds_sync <= 2'b11;
            ext_sync <= 2'b11;
        end else begin
            as_sync  <= {as_sync[0], as_n};
            uds_sync <= {uds_sync[0], uds_n};
            lds_sync <= {lds_sync[0], lds_n};
            ext_sync <= {ext_sync[0], ext_dtack_n};
        end
    end

    // Address classification; the descending loop leaves the lowest matching window selected.
    always_comb begin
        is_cfg     = (a[23:4] == 20'hFFFE0);
        is_shadow  = shadow_on && (a[23:20] == 4'hE);
        win_onehot = '0;
        win_hit    = 1'b0;
        for (int i = N_WIN - 1; i >= 0; i--) begin
            if (win_en[i] && (a[23:20] >= WIN_LO[4*i +: 4]) && (a[23:20] <= WIN_HI[4*i +: 4])) begin
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
                win_hit       = 1'b1;
            end
        end
    end

    assign wcnt_dec = (wcnt == '0) ? '0 : wcnt - 1'b1;

    // Next-state and next-register values; a dropped address strobe overrides everything.
    always_comb begin
        state_d   = state;
        wcnt_d    = wcnt;
        pcnt_d    = pcnt;
        dtack_d   = dtack_n;
        berr_d    = berr_n;
        alt_sel_d = alt_sel;
        rom_sel_d = rom_sel;
        a_remap_d = a_remap;
        win_en_d  = win_en;
        shadow_d  = shadow_on;
        claimed_d = claimed_q;
        case (state)
            S_IDLE: begin
                if (as_act) state_d = S_DECODE;
            end
            S_DECODE: begin
                a_remap_d = a[23:20];
                if (is_cfg) begin
                    if (a[3:1] == 3'd6) begin
                        win_en_d = '1;
                    end else if (a[3:1] == 3'd7) begin
                        shadow_d = 1'b1;
                    end else begin
                        for (int i = 0; i < N_WIN; i++) begin
                            if (a[3:1] == 3'(i)) win_en_d[i] = 1'b0;
                        end
                    end
                    claimed_d = 1'b1;
                    dtack_d   = 1'b0;
                    state_d   = S_ACK;
                end else if (is_shadow || win_hit) begin
                    if (is_shadow) begin
                        rom_sel_d = 1'b1;
                        a_remap_d = SHADOW_NIB;
                    end else begin
                        alt_sel_d = win_onehot;
                    end
                    claimed_d = 1'b1;
                    wcnt_d    = ALT_WAIT_L;
                    if ((ALT_WAIT_L == '0) && ram_rdy) begin
                        dtack_d = 1'b0;
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    claimed_d = 1'b0;
                    pcnt_d    = 8'd0;
                    state_d   = S_PASS;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_dec;
                if ((wcnt_dec == '0) && ram_rdy) begin
                    dtack_d = 1'b0;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_PASS: begin
                if (ext_act) begin
                    state_d = S_RELEASE;
                end else if (pcnt == BERR_L) begin
                    berr_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    pcnt_d = pcnt + 8'd1;
                end
            end
            default: ;
        endcase
        if ((state != S_IDLE) && !as_act) begin
            state_d   = S_IDLE;
            dtack_d   = 1'b1;
            berr_d    = 1'b1;
            wcnt_d    = '0;
            pcnt_d    = 8'd0;
            alt_sel_d = '0;
            rom_sel_d = 1'b0;
            claimed_d = 1'b0;
            win_en_d  = win_en;
            shadow_d  = shadow_on;
        end
    end

    // State and output registers; the fast-clock strap is captured only while in reset.
    always_ff @(posedge clkosc) begin
        if (rst) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            pcnt      <= 8'd0;
            dtack_n   <= 1'b1;
            berr_n    <= 1'b1;
            alt_sel   <= '0;
            rom_sel   <= 1'b0;
            a_remap   <= 4'h0;
            win_en    <= '1;
            shadow_on <= 1'b0;
            claimed_q <= 1'b0;
            fast_en_q <= fast_en;
        end else begin
            state     <= state_d;
            wcnt      <= wcnt_d;
            pcnt      <= pcnt_d;
            dtack_n   <= dtack_d;
            berr_n    <= berr_d;
            alt_sel   <= alt_sel_d;
            rom_sel   <= rom_sel_d;
            a_remap   <= a_remap_d;
            win_en    <= win_en_d;
            shadow_on <= shadow_d;
            claimed_q <= claimed_d;
        end
    end

    // Clock-mux select: the fast clock is used only while a claimed access is in flight.
    always_comb begin
        slow = 1'b1;
        if (fast_en_q) begin
            if (state == S_DECODE) begin
                slow = ~(is_cfg | is_shadow | win_hit);
            end else if ((state == S_WAIT) || (state == S_ACK) || (state == S_RELEASE)) begin
                slow = ~claimed_q;
            end
        end
    end

endmodule

// File: tb/tb_altram_bus_ctrl.sv
// tb/tb_altram_bus_ctrl.sv - self-checking randomized bench for altram_bus_ctrl
module tb_altram_bus_ctrl;

    localparam int AW = 2;
    localparam int BC = 255;

    logic        clkosc = 1'b0;
    logic        rst, as_n, uds_n, lds_n, rw;
    logic [23:1] a;
    logic        ext_dtack_n, ram_rdy, fast_en;
    logic        dtack_n, berr_n, rom_sel, slow, shadow_on;
    logic [1:0]  alt_sel, win_en;
    logic [3:0]  a_remap;

    int total = 0;
    int bad   = 0;

    logic [1:0] win_en_m;
    logic       shadow_m, fast_m;
    logic [3:0] lo_m [2] = '{4'h4, 4'h8};
    logic [3:0] hi_m [2] = '{4'h7, 4'hB};

    altram_bus_ctrl dut (
        .clkosc(clkosc), .rst(rst), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
        .a(a), .ext_dtack_n(ext_dtack_n), .ram_rdy(ram_rdy), .fast_en(fast_en),
        .dtack_n(dtack_n), .berr_n(berr_n), .alt_sel(alt_sel), .rom_sel(rom_sel),
        .a_remap(a_remap), .slow(slow), .win_en(win_en), .shadow_on(shadow_on)
    );

    always #5 clkosc = ~clkosc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clkosc);
        @(negedge clkosc);
    endtask

    // 0 = config, 1 = shadow, 2 = window w, 3 = unclaimed
    function automatic int classify(input logic [23:0] addr, output int w);
        w = 0;
        if (addr[23:4] == 20'hFFFE0) return 0;
        if (shadow_m && addr[23:20] == 4'hE) return 1;
        for (int i = 0; i < 2; i++) begin
            if (win_en_m[i] && addr[23:20] >= lo_m[i] && addr[23:20] <= hi_m[i]) begin
                w = i;
                return 2;
            end
        end
        return 3;
    endfunction

    task automatic access(input logic [23:0] addr, input int rdy_m, input int ext_m, input int hold);
        int kind, w, ack_k, exp_k;
        logic dt_seen, be_seen;
        logic [2:0] off;
        kind = classify(addr, w);
        a = addr[23:1];
        rw = 1'($urandom_range(0, 1));
        uds_n = 1'($urandom_range(0, 1));
        lds_n = 1'b0;
        if (kind == 3) begin
            ext_dtack_n = 1'b1;
            as_n = 1'b0;
            dt_seen = 1'b0;
            be_seen = 1'b0;
            for (int k = 0; k <= ext_m + hold; k++) begin
                tick;
                if (!dtack_n) dt_seen = 1'b1;
                if (!berr_n) be_seen = 1'b1;
                if (k == ext_m) ext_dtack_n = 1'b0;
            end
            check_eq("pass_no_dtack", dt_seen, 0);
            check_eq("pass_no_berr", be_seen, 0);
            check_eq("pass_slow", slow, 1);
            check_eq("pass_sel", {alt_sel, rom_sel}, 0);
            as_n = 1'b1;
            tick; tick; tick;
            ext_dtack_n = 1'b1;
            check_eq("pass_idle_dtack", dtack_n, 1);
        end else begin
            if (rdy_m > 0) ram_rdy = 1'b0;
            as_n = 1'b0;
            ack_k = -1;
            exp_k = (kind == 0) ? 3 : (((3 + AW) > (rdy_m + 1)) ? (3 + AW) : (rdy_m + 1));
            for (int k = 0; k < 40 && ack_k < 0; k++) begin
                tick;
                if (!dtack_n) ack_k = k;
                else if (k == rdy_m) ram_rdy = 1'b1;
            end
            check_eq("ack_latency", ack_k, exp_k);
            check_eq("ack_alt_sel", alt_sel, (kind == 2) ? (2'b01 << w) : 2'b00);
            check_eq("ack_rom_sel", rom_sel, (kind == 1) ? 1 : 0);
            check_eq("ack_a_remap", a_remap, (kind == 1) ? 4'hB : addr[23:20]);
            check_eq("ack_slow", slow, fast_m ? 0 : 1);
            check_eq("ack_berr", berr_n, 1);
            if (kind == 0) begin
                off = addr[3:1];
                if (off < 3'd2) win_en_m[off[0]] = 1'b0;
                else if (off == 3'd6) win_en_m = 2'b11;
                else if (off == 3'd7) shadow_m = 1'b1;
            end
            ram_rdy = 1'b1;
            as_n = 1'b1;
            tick; tick;
            check_eq("dtack_hold", dtack_n, 0);
            tick;
            check_eq("dtack_release", dtack_n, 1);
            check_eq("release_sel", {alt_sel, rom_sel}, 0);
        end
        check_eq("win_en", win_en, win_en_m);
        check_eq("shadow_on", shadow_on, shadow_m);
        uds_n = 1'b1;
        lds_n = 1'b1;
        tick;
    endtask

    initial begin
        int berr_k, nib;
        logic dt_seen, slow_bad;
        logic [23:0] addr;
        rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
        a = '0; ext_dtack_n = 1'b1; ram_rdy = 1'b1; fast_en = 1'b1;
        win_en_m = 2'b11; shadow_m = 1'b0; fast_m = 1'b1;
        tick; tick; tick;
        check_eq("rst_dtack", dtack_n, 1);
        check_eq("rst_berr", berr_n, 1);
        check_eq("rst_sel", {alt_sel, rom_sel}, 0);
        check_eq("rst_a_remap", a_remap, 0);
        check_eq("rst_slow", slow, 1);
        check_eq("rst_win_en", win_en, 2'b11);
        check_eq("rst_shadow", shadow_on, 0);
        rst = 1'b0;
        tick;

        access(24'h400000, 0, 0, 0);
        access(24'hFFFE0E, 0, 0, 0);
        access(24'hE00000, 0, 0, 0);
        access(24'hFFFE00, 0, 0, 0);
        access(24'h400000, 0, 10, 270);
        access(24'hFFFE0C, 0, 0, 0);

        // unclaimed access times out into a bus error
        a = 24'hF00000 >> 1;
        as_n = 1'b0;
        berr_k = -1;
        dt_seen = 1'b0;
        for (int k = 0; k < 400 && berr_k < 0; k++) begin
            tick;
            if (!dtack_n) dt_seen = 1'b1;
            if (!berr_n) berr_k = k;
        end
        check_eq("berr_latency", berr_k, 3 + BC + 1);
        check_eq("berr_no_dtack", dt_seen, 0);
        repeat (5) tick;
        check_eq("berr_held", berr_n, 0);
        as_n = 1'b1;
        tick; tick;
        check_eq("berr_hold_sync", berr_n, 0);
        tick;
        check_eq("berr_release", berr_n, 1);
        tick;

        access(24'h400000, 8, 0, 0);

        // strobe dropped while waiting on the SDRAM controller
        a = 24'h400000 >> 1;
        ram_rdy = 1'b0;
        as_n = 1'b0;
        dt_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (!dtack_n) dt_seen = 1'b1;
            if (k == 6) check_eq("abort_wait_sel", alt_sel, 2'b01);
        end
        as_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (!dtack_n) dt_seen = 1'b1;
        end
        check_eq("abort_no_dtack", dt_seen, 0);
        check_eq("abort_sel", alt_sel, 0);
        ram_rdy = 1'b1;
        tick;

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                addr = {20'hFFFE0, 3'($urandom_range(0, 7)), 1'b0};
            end else begin
                nib = $urandom_range(0, 15);
                addr = {4'(nib), 20'($urandom)};
                addr[0] = 1'b0;
            end
            access(addr, $urandom_range(0, 9), $urandom_range(2, 10), 4);
        end

        // strap captured low during reset keeps the bus clock selected
        rst = 1'b1;
        fast_en = 1'b0;
        tick; tick;
        rst = 1'b0;
        fast_en = 1'b1;
        fast_m = 1'b0;
        win_en_m = 2'b11;
        shadow_m = 1'b0;
        tick;
        check_eq("slow_strap_idle", slow, 1);
        access(24'hFFFE00, 0, 0, 0);
        a = 24'h800000 >> 1;
        as_n = 1'b0;
        slow_bad = 1'b0;
        for (int k = 0; k < 20 && dtack_n; k++) begin
            tick;
            if (slow !== 1'b1) slow_bad = 1'b1;
        end
        check_eq("slow_strap_access", slow_bad, 0);
        check_eq("strap_ack_sel", {dtack_n, alt_sel}, 3'b010);
        rst = 1'b1;
        tick;
        check_eq("midrst_dtack", dtack_n, 1);
        check_eq("midrst_win_en", win_en, 2'b11);
        check_eq("midrst_sel", alt_sel, 0);
        rst = 1'b0;
        as_n = 1'b1;
        fast_m = 1'b1;
        tick; tick; tick;
        check_eq("post_rst_slow", slow, 1);
        win_en_m = 2'b11;
        access(24'h900000, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
